// File: rtl/rv32i_types.sv
// Shared types for the instruction/data memory arbiter.
package rv32i_types;
  typedef enum logic [1:0] {IDLE, GAP, SERVE_I, SERVE_D} arb_state_t;
  typedef enum logic {I, D} arb_port_t;
endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory bus. Requests are registered
// before reaching the bus, and an optional idle gap separates transactions.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int MIN_IDLE    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byte_enable,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] GAP_LOAD = (MIN_IDLE > 0) ? 2'(MIN_IDLE - 1) : 2'd0;

  arb_state_t  state, state_d;
  arb_port_t   last_grant, grant;
  logic        start;
  logic [1:0]  gap_cnt;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_be;
  logic        lat_write;
  logic        d_pend, serving;

  assign d_pend  = d_read | d_write;
  assign serving = (state == SERVE_I) || (state == SERVE_D);

  always_comb begin
    state_d = state;
    grant   = D;
    start   = 1'b0;
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    case (state)
      IDLE: begin
        if (i_read && d_pend) begin
          start = 1'b1;
          // Round robin favours whichever port was not served last.
          grant = (ROUND_ROBIN != 0 && last_grant == D) ? I : D;
        end else if (d_pend) begin
          start = 1'b1;
          grant = D;
        end else if (i_read) begin
          start = 1'b1;
          grant = I;
        end
        if (start) state_d = (grant == I) ? SERVE_I : SERVE_D;
      end
      GAP: if (gap_cnt == 2'd0) state_d = IDLE;
      SERVE_I: if (mem_resp) begin
        i_resp  = 1'b1;
        state_d = (MIN_IDLE > 0) ? GAP : IDLE;
      end
      SERVE_D: if (mem_resp) begin
        d_resp  = 1'b1;
        state_d = (MIN_IDLE > 0) ? GAP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign i_rdata = i_resp ? mem_rdata : 32'd0;
  assign d_rdata = d_resp ? mem_rdata : 32'd0;

  // Bus is driven purely from state and latched registers.
  assign mem_read        = (state == SERVE_I) || (state == SERVE_D && !lat_write);
  assign mem_write       = (state == SERVE_D) && lat_write;
  assign mem_address     = serving ? lat_addr : 32'd0;
  assign mem_wdata       = (state == SERVE_D) ? lat_wdata : 32'd0;
  assign mem_byte_enable = serving ? lat_be : 4'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= I;
      gap_cnt    <= 2'd0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_be     <= 4'd0;
      lat_write  <= 1'b0;
    end else begin
      state <= state_d;
      if (start) begin
        if (grant == I) begin
          lat_addr  <= i_address;
          lat_wdata <= 32'd0;
          lat_be    <= 4'hF;
          lat_write <= 1'b0;
        end else begin
          // A simultaneous read+write is treated as a write.
          lat_addr  <= d_address;
          lat_wdata <= d_wdata;
          lat_be    <= d_write ? d_byte_enable : 4'hF;
          lat_write <= d_write;
        end
      end
      if (i_resp) last_grant <= I;
      if (d_resp) last_grant <= D;
      if (state_d == GAP && state != GAP) gap_cnt <= GAP_LOAD;
      else if (state == GAP && gap_cnt != 2'd0) gap_cnt <= gap_cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance plus a fixed-priority
// instance sharing the same stimulus and memory response.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_read, d_read, d_write, mem_resp;
  logic [31:0] i_address, d_address, d_wdata, mem_rdata;
  logic [3:0]  d_byte_enable;

  logic [31:0] i_rdata, d_rdata, mem_address, mem_wdata;
  logic        i_resp, d_resp, mem_read, mem_write;
  logic [3:0]  mem_byte_enable;

  logic [31:0] r0_i_rdata, r0_d_rdata, r0_mem_address, r0_mem_wdata;
  logic        r0_i_resp, r0_d_resp, r0_mem_read, r0_mem_write;
  logic [3:0]  r0_mem_byte_enable;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ROUND_ROBIN(1), .MIN_IDLE(1)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ROUND_ROBIN(0), .MIN_IDLE(1)) dut0 (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(r0_i_rdata), .i_resp(r0_i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_rdata(r0_d_rdata), .d_resp(r0_d_resp),
    .mem_read(r0_mem_read), .mem_write(r0_mem_write), .mem_address(r0_mem_address),
    .mem_wdata(r0_mem_wdata), .mem_byte_enable(r0_mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_read = 0; i_address = 0; d_read = 0; d_write = 0;
    d_address = 0; d_wdata = 0; d_byte_enable = 0;
    mem_resp = 0; mem_rdata = 0;
  endtask

  task automatic reset_pulse();
    rst = 0;
    tick();
    rst = 1;
  endtask

  // Bounded wait for the round-robin instance to start a bus transaction.
  task automatic wait_strobe(input string tag);
    int n = 0;
    while (!(mem_read || mem_write) && n < 6) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, mem_read | mem_write}, 32'd1);
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    tick();
    #1;
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_resp", {30'd0, i_resp, d_resp}, 32'd0);
    rst = 1;

    // Single fetch at 0x60, memory answers on the third serve cycle.
    tick();
    i_read = 1; i_address = 32'h60;
    tick();
    chk("f_mem_read", {31'd0, mem_read}, 32'd1);
    chk("f_mem_write", {31'd0, mem_write}, 32'd0);
    chk("f_mem_address", mem_address, 32'h60);
    chk("f_mem_be", {28'd0, mem_byte_enable}, 32'hF);
    chk("f_no_early_resp", {31'd0, i_resp}, 32'd0);
    tick();
    tick();
    mem_resp = 1; mem_rdata = 32'h12345678;
    #1;
    chk("f_i_resp", {31'd0, i_resp}, 32'd1);
    chk("f_i_rdata", i_rdata, 32'h12345678);
    chk("f_d_resp", {31'd0, d_resp}, 32'd0);
    tick();
    i_read = 0;
    #1;
    // In GAP with mem_resp still high: must be ignored.
    chk("gap_mem_read", {31'd0, mem_read}, 32'd0);
    chk("gap_spurious_resp", {30'd0, i_resp, d_resp}, 32'd0);
    chk("gap_i_rdata", i_rdata, 32'd0);
    tick();
    #1;
    chk("idle_spurious_resp", {30'd0, i_resp, d_resp}, 32'd0);
    chk("idle_mem_read", {31'd0, mem_read}, 32'd0);
    tick();
    mem_resp = 0; mem_rdata = 0;
    #1;
    chk("idle_after_spurious", {30'd0, mem_read, mem_write}, 32'd0);

    // Contention after reset: data write wins first, then fetch.
    reset_pulse();
    i_read = 1; i_address = 32'h60;
    d_write = 1; d_address = 32'h100; d_wdata = 32'hDEADBEEF; d_byte_enable = 4'b0011;
    tick();
    chk("c_mem_write", {31'd0, mem_write}, 32'd1);
    chk("c_mem_read", {31'd0, mem_read}, 32'd0);
    chk("c_mem_address", mem_address, 32'h100);
    chk("c_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("c_mem_be", {28'd0, mem_byte_enable}, 32'h3);
    mem_resp = 1;
    #1;
    chk("c_d_resp", {31'd0, d_resp}, 32'd1);
    chk("c_i_resp", {31'd0, i_resp}, 32'd0);
    tick();
    d_write = 0; mem_resp = 0;
    chk("c_gap_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    tick();
    chk("c_idle_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    tick();
    chk("c_i_mem_read", {31'd0, mem_read}, 32'd1);
    chk("c_i_mem_address", mem_address, 32'h60);
    mem_resp = 1; mem_rdata = 32'hA5A5A5A5;
    #1;
    chk("c_i_resp2", {31'd0, i_resp}, 32'd1);
    chk("c_i_rdata2", i_rdata, 32'hA5A5A5A5);
    tick();
    i_read = 0; mem_resp = 0;
    tick();

    // Both ports held: round robin alternates D,I,D,I; fixed priority always D.
    clear_inputs();
    reset_pulse();
    i_read = 1; i_address = 32'h60;
    d_write = 1; d_address = 32'h100; d_wdata = 32'h0BADF00D; d_byte_enable = 4'hF;
    for (int k = 0; k < 4; k++) begin
      tick();
      wait_strobe($sformatf("alt%0d_timeout", k));
      chk($sformatf("alt%0d_addr", k), mem_address, (k % 2 == 0) ? 32'h100 : 32'h60);
      chk($sformatf("alt%0d_r0_addr", k), r0_mem_address, 32'h100);
      chk($sformatf("alt%0d_r0_write", k), {31'd0, r0_mem_write}, 32'd1);
      mem_resp = 1; mem_rdata = k;
      #1;
      chk($sformatf("alt%0d_d_resp", k), {31'd0, d_resp}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("alt%0d_i_resp", k), {31'd0, i_resp}, (k % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("alt%0d_r0_d_resp", k), {31'd0, r0_d_resp}, 32'd1);
      tick();
      mem_resp = 0;
    end

    // Reset mid-service abandons the data write; pending fetch served after.
    clear_inputs();
    reset_pulse();
    i_read = 1; i_address = 32'h60;
    d_write = 1; d_address = 32'h300; d_byte_enable = 4'hF;
    tick();
    chk("r_mem_write", {31'd0, mem_write}, 32'd1);
    mem_resp = 1;
    rst = 0;
    #1;
    chk("r_abort_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("r_abort_addr", mem_address, 32'd0);
    chk("r_abort_resp", {30'd0, i_resp, d_resp}, 32'd0);
    mem_resp = 0; d_write = 0;
    tick();
    rst = 1;
    tick();
    chk("r_i_mem_read", {31'd0, mem_read}, 32'd1);
    chk("r_i_mem_address", mem_address, 32'h60);
    mem_resp = 1; mem_rdata = 32'hCAFE0001;
    #1;
    chk("r_i_resp", {31'd0, i_resp}, 32'd1);
    chk("r_i_rdata", i_rdata, 32'hCAFE0001);
    tick();
    mem_resp = 0; i_read = 0;

    // Read and write together are treated as a write.
    d_read = 1; d_write = 1; d_address = 32'h200; d_wdata = 32'h55; d_byte_enable = 4'hC;
    wait_strobe("rw_timeout");
    chk("rw_mem_write", {31'd0, mem_write}, 32'd1);
    chk("rw_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rw_mem_address", mem_address, 32'h200);
    chk("rw_mem_be", {28'd0, mem_byte_enable}, 32'hC);
    mem_resp = 1;
    #1;
    chk("rw_d_resp", {31'd0, d_resp}, 32'd1);
    tick();
    clear_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
